// File: rtl/fetch_unit.sv
// fetch_unit: byte-stream instruction fetch stage.
// Issues one outstanding byte read at a time on the memory bus and buffers
// returned bytes, each tagged with its address, in a small FIFO that feeds
// the consumer through a valid/ready handshake. pc_load redirects fetch:
// the FIFO is flushed and fetch restarts at the new target.
//
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   run                  fetch enable (gates new requests only)
//   pc_load, pc_value    redirect strobe and target
//   mem_req, mem_addr    read request / address, held until mem_ack
//   mem_ack, mem_data    request completion and returned byte
//   byte_out, byte_pc    FIFO head byte and its address
//   byte_valid           FIFO non-empty
//   byte_ready           consumer accepts the head byte
//   busy                 request outstanding or draining
//
// state | meaning
// IDLE  | no request on the bus
// REQ   | request outstanding; returned byte is kept
// DRAIN | request outstanding after a redirect; returned byte is dropped
`timescale 1ns/1ps

module fetch_unit #(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter int unsigned            FIFO_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [7:0]            mem_data,
  output logic [7:0]            byte_out,
  output logic [ADDR_WIDTH-1:0] byte_pc,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_WIDTH-1:0] redirect_q, redirect_d;
  logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
  logic [7:0]            fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  // A redirect always flushes, so it suppresses both push and pop.
  assign push = (state_q == REQ) && mem_ack && !pc_load;
  assign pop  = (count_q != '0) && byte_ready && !pc_load;

  always_comb begin
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    if (pc_load) begin
      rd_d      = '0;
      wr_d      = '0;
      count_d   = '0;
      head_pc_d = pc_value;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop) begin
        rd_d      = rd_q + PW'(1);
        head_pc_d = head_pc_q + ADDR_WIDTH'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    redirect_d   = redirect_q;
    case (state_q)
      IDLE: begin
        if (pc_load) fetch_addr_d = pc_value;
        else if (run && (count_q < DEPTH_C)) state_d = REQ;
      end
      REQ: begin
        if (mem_ack && pc_load) begin
          fetch_addr_d = pc_value;
          state_d      = IDLE;
        end else if (mem_ack) begin
          fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
          // Decide on the post-update fill level so the FIFO never overflows.
          state_d      = (run && (count_d < DEPTH_C)) ? REQ : IDLE;
        end else if (pc_load) begin
          // Request cannot be withdrawn: keep the old address on the bus.
          redirect_d = pc_value;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_ack && pc_load) begin
          fetch_addr_d = pc_value;
          state_d      = IDLE;
        end else if (mem_ack) begin
          fetch_addr_d = redirect_q;
          state_d      = IDLE;
        end else if (pc_load) begin
          redirect_d = pc_value;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      fetch_addr_q <= RESET_VECTOR;
      redirect_q   <= RESET_VECTOR;
      head_pc_q    <= RESET_VECTOR;
      rd_q         <= '0;
      wr_q         <= '0;
      count_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      redirect_q   <= redirect_d;
      head_pc_q    <= head_pc_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      count_q      <= count_d;
      if (push) fifo_q[wr_q] <= mem_data;
    end
  end

  assign mem_req    = (state_q != IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_addr   = fetch_addr_q;
  assign byte_out   = fifo_q[rd_q];
  assign byte_pc    = head_pc_q;
  assign byte_valid = (count_q != '0);

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps

module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h100;

  logic        clk = 1'b0;
  logic        reset, run, pc_load, byte_ready, ack_en;
  logic [31:0] pc_value;
  logic        mem_req, mem_ack, byte_valid, busy;
  logic [31:0] mem_addr, byte_pc;
  logic [7:0]  mem_data, byte_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  logic [31:0] ack_log [$];
  logic [31:0] m_addr, m_redir;
  logic        m_drain;

  always #5 clk = ~clk;

  // Memory returns the low address byte; acks whenever enabled.
  assign mem_ack  = ack_en & mem_req;
  assign mem_data = mem_addr[7:0];

  fetch_unit #(.ADDR_WIDTH(32), .FIFO_DEPTH(4), .RESET_VECTOR(RV)) dut (
    .clk(clk), .reset(reset), .run(run), .pc_load(pc_load), .pc_value(pc_value),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .byte_out(byte_out), .byte_pc(byte_pc), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model, evaluated on the falling edge with all inputs for the
  // coming rising edge already settled.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      m_addr  = RV;
      m_redir = RV;
      m_drain = 1'b0;
    end else begin
      logic [31:0] e;
      if (mem_req) chk("mem_addr", mem_addr, m_addr);
      chk("byte_valid", {31'b0, byte_valid}, {31'b0, exp_q.size() != 0});
      if (byte_valid && byte_ready && !pc_load && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("byte_out", {24'b0, byte_out}, {24'b0, e[7:0]});
        chk("byte_pc", byte_pc, e);
      end
      if (mem_req && mem_ack) begin
        if (pc_load) begin
          exp_q.delete();
          m_addr  = pc_value;
          m_drain = 1'b0;
        end else if (m_drain) begin
          m_addr  = m_redir;
          m_drain = 1'b0;
        end else begin
          exp_q.push_back(m_addr);
          ack_log.push_back(mem_addr);
          m_addr = m_addr + 1;
        end
      end else if (pc_load) begin
        exp_q.delete();
        if (mem_req) begin
          m_drain = 1'b1;
          m_redir = pc_value;
        end else begin
          m_addr = pc_value;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base, a;
    int vcnt, rcnt;
    reset = 1'b1; run = 1'b0; pc_load = 1'b0; pc_value = '0;
    ack_en = 1'b0; byte_ready = 1'b0;
    #3;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_valid", {31'b0, byte_valid}, 0);
    chk("rst_mem_addr", mem_addr, RV);
    chk("rst_byte_pc", byte_pc, RV);
    chk("rst_byte_out", {24'b0, byte_out}, 0);
    step(); step();
    reset = 1'b0;

    // Streaming from the reset vector
    run = 1'b1; ack_en = 1'b1; byte_ready = 1'b1;
    repeat (6) step();
    vcnt = 0; rcnt = 0;
    repeat (10) begin
      step();
      vcnt += int'(byte_valid);
      rcnt += int'(mem_req & mem_ack);
    end
    chk("t1_valid_cycles", vcnt, 10);
    chk("t1_ack_cycles", rcnt, 10);

    // Back-pressure fills the FIFO and stops fetch
    run = 1'b0;
    repeat (6) step();
    chk("t2_idle", {31'b0, mem_req}, 0);
    chk("t2_empty", {31'b0, byte_valid}, 0);
    base = mem_addr;
    byte_ready = 1'b0; run = 1'b1;
    ack_log.delete();
    repeat (12) step();
    chk("t2_acks", ack_log.size(), 4);
    chk("t2_req_stopped", {31'b0, mem_req}, 0);
    chk("t2_valid", {31'b0, byte_valid}, 1);
    chk("t2_head", {24'b0, byte_out}, {24'b0, base[7:0]});
    byte_ready = 1'b1;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    chk("t2_resume_addr", mem_addr, base + 4);

    // Redirect while a request is stalled
    ack_en = 1'b0;
    step(); step();
    a = mem_addr;
    chk("t3_req_pending", {31'b0, mem_req}, 1);
    pc_value = 32'h2000; pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    repeat (3) begin
      step();
      chk("t3_addr_hold", mem_addr, a);
    end
    chk("t3_busy", {31'b0, busy}, 1);
    chk("t3_flushed", {31'b0, byte_valid}, 0);
    ack_en = 1'b1;
    for (int i = 0; i < 20 && !byte_valid; i++) step();
    chk("t3_first_pc", byte_pc, 32'h2000);
    chk("t3_first_byte", {24'b0, byte_out}, 0);

    // Redirect coinciding with ack and pop
    repeat (4) step();
    chk("t4_pre_req", {31'b0, mem_req}, 1);
    chk("t4_pre_valid", {31'b0, byte_valid}, 1);
    pc_value = 32'h40; pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    chk("t4_valid_drop", {31'b0, byte_valid}, 0);
    chk("t4_idle", {31'b0, mem_req}, 0);
    step();
    chk("t4_req", {31'b0, mem_req}, 1);
    chk("t4_addr", mem_addr, 32'h40);

    // Address wrap
    pc_value = 32'hFFFF_FFFE; pc_load = 1'b1;
    step();
    pc_load = 1'b0;
    ack_log.delete();
    repeat (8) step();
    chk("t5_count", {31'b0, ack_log.size() >= 3}, 1);
    if (ack_log.size() >= 3) begin
      chk("t5_addr0", ack_log[0], 32'hFFFF_FFFE);
      chk("t5_addr1", ack_log[1], 32'hFFFF_FFFF);
      chk("t5_addr2", ack_log[2], 32'h0000_0000);
    end

    // Asynchronous reset mid-request with 3 bytes buffered
    run = 1'b0;
    repeat (6) step();
    byte_ready = 1'b0;
    ack_log.delete();
    run = 1'b1;
    for (int i = 0; i < 20 && ack_log.size() < 3; i++) step();
    ack_en = 1'b0;
    chk("t6_three", ack_log.size(), 3);
    step();
    chk("t6_req", {31'b0, mem_req}, 1);
    chk("t6_valid", {31'b0, byte_valid}, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_req", {31'b0, mem_req}, 0);
    chk("t6_async_valid", {31'b0, byte_valid}, 0);
    chk("t6_async_busy", {31'b0, busy}, 0);
    chk("t6_async_addr", mem_addr, RV);
    step();
    reset = 1'b0;
    ack_en = 1'b1; byte_ready = 1'b1;
    for (int i = 0; i < 10 && !mem_req; i++) step();
    chk("t6_restart", mem_addr, RV);
    repeat (6) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
